// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and default operand width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the per-bit datapath of serial_adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic sum,
    output logic carry
);

    assign sum   = A ^ B ^ C;
    assign carry = (A & B) | (C & (A ^ B));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: computes {carry,sum} = A + B + C one bit per clock, LSB first,
// using a single full adder and a carry flop. Result is valid from the done pulse on.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;

    logic fa_sum;
    logic fa_carry;

    full_adder u_full_adder (
        .A     (a_sr_q[0]),
        .B     (b_sr_q[0]),
        .C     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    a_sr_d   = A;
                    b_sr_d   = B;
                    sum_sr_d = '0;
                    carry_d  = C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it is async-cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_sr_q;
    assign carry = carry_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, scoreboard and directed corner cases.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         c_in  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .C     (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, required done=0 (no pending op, t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_sum", {24'd0, sum}, {24'd0, mon_e.s});
                check("result_carry", {31'd0, carry}, {31'd0, mon_e.co});
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic eco, input bit disturb);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        sb_q.push_back('{s: es, co: eco});
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            if (i <= W) begin
                check("busy_in_run", {31'd0, busy}, 32'd1);
                check("no_done_in_run", {31'd0, done}, 32'd0);
            end else begin
                check("done_latency", {31'd0, done}, 32'd1);
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
            if (disturb && i < W) begin
                start = i[0];
                a_in  = W'($urandom);
                b_in  = W'($urandom);
                c_in  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input logic [W-1:0] es, input logic eco);
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("hold_sum", {24'd0, sum}, {24'd0, es});
        check("hold_carry", {31'd0, carry}, {31'd0, eco});
    endtask

    initial begin
        logic [W:0] full;
        logic [W-1:0] ra, rb;
        logic rc;

        vecs[0] = '{a: 8'h3C, b: 8'h42, c: 1'b0, s: 8'h7E, co: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, c: 1'b1, s: 8'h00, co: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, c: 1'b0, s: 8'h00, co: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'h00, c: 1'b1, s: 8'h80, co: 1'b0};
        vecs[7] = '{a: 8'h55, b: 8'hAA, c: 1'b0, s: 8'hFF, co: 1'b0};

        // Reset state
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors; first start goes in right after reset release
        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].s, vecs[k].co, 1'b0);
            idle_check(vecs[k].s, vecs[k].co);
        end

        // Back-to-back: restart in the done cycle, busy must follow done without a gap
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        idle_check(8'h30, 1'b0);

        // Start pulses and operand changes during RUN are ignored
        run_op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1);
        idle_check(8'h7E, 1'b0);

        // Random operands against a bench-side arithmetic model
        for (int r = 0; r < 6; r++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, full[W-1:0], full[W], 1'b0);
            idle_check(full[W-1:0], full[W]);
        end

        // Reset asserted at RUN bit 4 aborts the operation
        start = 1'b1;
        a_in  = 8'hC3;
        b_in  = 8'h3C;
        c_in  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_carry", {31'd0, carry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {31'd0, done}, 32'd0);
        end
        run_op(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0);
        idle_check(8'h00, 1'b1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: the operation request, sampled on the clk rising edge.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A, sampled only when start is accepted.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B, sampled only when start is accepted.
REQ-008 The block SHALL have port C, input, 1 bit: the carry-in, sampled only when start is accepted.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result, A+B+C modulo 2^WIDTH.
REQ-012 The block SHALL have port carry, output, 1 bit: the carry-out of A+B+C.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a clock edge SHALL load the A/B shift registers, set the carry flop to C, clear the bit counter and move to RUN.
REQ-015 In RUN, each clock edge SHALL perform these actions:
  - Add A_sr[0], B_sr[0] and the carry flop in one full-adder instance.
  - Shift the sum bit into sum_sr from the MSB side.
  - Shift A_sr and B_sr right by one.
  - Update the carry flop.
  - Increment the counter.
REQ-016 When the counter reaches WIDTH-1 in RUN, the next edge SHALL process the final bit and move to DONE.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH, which is WIDTH+1 cycles after acceptance.
REQ-018 busy SHALL be high exactly while the state is RUN.
REQ-019 done SHALL be high exactly while the state is DONE, and DONE SHALL last one cycle unless start is re-asserted.
REQ-020 DONE with start=0 SHALL return to IDLE.
REQ-021 sum and carry SHALL be valid from the done cycle onward and SHALL hold until the next accepted start.
REQ-022 During RUN, sum and carry SHALL show intermediate values that are not guaranteed.
REQ-023 start asserted during RUN SHALL be ignored, with no reload and no effect on the current result.
REQ-024 start asserted during DONE SHALL be accepted (back-to-back operation), so that done is followed immediately by busy on the next cycle.
REQ-025 Operands SHALL be captured at acceptance, so changes on A, B or C during RUN SHALL have no effect.
REQ-026 Arithmetic SHALL be unsigned, with {carry,sum} = A + B + C exactly (WIDTH+1 bits), including the all-ones wrap-around case.

Reset
REQ-027 rst_n low SHALL immediately force the following, independent of clk:
  - state IDLE;
  - busy=0 and done=0;
  - sum=0 and carry=0;
  - counter, shift registers and carry flop all 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow the release of reset.
REQ-029 After rst_n is released, the first start SHALL be accepted at the first rising clk edge at which it is high.

Structure
REQ-030 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL reside in the shared package adder_pkg.
REQ-031 The per-bit addition SHALL be done by exactly one instance of the existing combinational sub-module full_adder (inputs A, B, C; outputs sum, carry).
REQ-032 All other logic (FSM, counter, shift registers, carry flop) SHALL be local to serial_adder.
REQ-033 The counter width SHALL be $clog2(WIDTH).

Verification
REQ-034 With WIDTH=8 the bench SHALL cover these directed scenarios:
  - A=0x3C, B=0x42, C=0 -> sum=0x7E, carry=0, with done exactly 9 cycles after start acceptance.
  - A=0xFF, B=0x01, C=0 -> sum=0x00, carry=1 (wrap-around).
  - A=0xA5, B=0x5A, C=1 -> sum=0x00, carry=1. Then A=0x00, B=0x00, C=0 -> sum=0x00, carry=0.
  - Start re-asserted in the done cycle with A=0x10, B=0x20, C=0 -> second done 9 cycles later with sum=0x30, and busy never gaps.
  - Start pulses and A/B/C changes during RUN -> the result still equals the originally captured operands, with a single done.
  - rst_n pulsed low at RUN bit 4 -> immediate outputs busy=0, done=0, sum=0, carry=0, and no done follows. A new start then yields a correct result.
